// File: rtl/barrett_quotient_correct_if.sv
// Handshake/data bundle for barrett_quotient_correct.
//   master : upstream/downstream side (drives x, m, q, in_valid, out_ready)
//   slave  : the correction block (drives in_ready, out_valid, r, corr_cnt, err)
// Signals:
//   in_valid/in_ready   operand handshake
//   x (WIDTH+2)         operand to reduce
//   m (WIDTH)           modulus, must be non-zero
//   q (2)               quotient estimate
//   out_valid/out_ready result handshake
//   r (WIDTH)           reduced residue
//   corr_cnt (3)        corrections applied
//   err                 reduction failure flag
interface barrett_quotient_correct_if #(
  parameter int WIDTH = 110
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH+1:0] x;
  logic [WIDTH-1:0] m;
  logic [1:0]       q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [2:0]       corr_cnt;
  logic             err;

  modport master (
    output in_valid, x, m, q, out_ready,
    input  in_ready, out_valid, r, corr_cnt, err
  );

  modport slave (
    input  in_valid, x, m, q, out_ready,
    output in_ready, out_valid, r, corr_cnt, err
  );
endinterface

// File: rtl/barrett_quotient_correct.sv
// Barrett quotient correction stage: r = x - q*m, followed by up to MAX_CORR
// conditional subtractions of m so that r < m. One operand in flight at a time.
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    barrett_quotient_correct_if.slave (operand in, residue out)
// Optional feature: define QCORR_ERR_EN to build the underflow/overrun
// detection that drives err; otherwise err is tied low.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SUB   | acc <= x - q*m
// CORR  | one conditional subtraction of m per cycle
// DONE  | result presented, held until out_ready
module barrett_quotient_correct #(
  parameter int WIDTH    = 110,
  parameter int MAX_CORR = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  barrett_quotient_correct_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_CORR);

  state_t           state, state_nxt;
  logic [WIDTH+1:0] x_q;
  logic [WIDTH-1:0] m_q;
  logic [1:0]       q_q;
  logic [WIDTH+1:0] acc;
  logic [2:0]       cnt;

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] qm;
  logic             acc_ge_m;
  logic             do_corr;

  // q*m fits in WIDTH+2 bits since q <= 3 and m < 2^WIDTH.
  assign m_ext    = {2'b00, m_q};
  assign qm       = (q_q[0] ? m_ext : '0) + (q_q[1] ? {1'b0, m_q, 1'b0} : '0);
  assign acc_ge_m = (acc >= m_ext);
  assign do_corr  = (state == CORR) && acc_ge_m && (cnt < MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = SUB;
      SUB:  state_nxt = CORR;
      CORR: if (!do_corr) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      m_q <= '0;
      q_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q <= bus.x;
            m_q <= bus.m;
            q_q <= bus.q;
          end
        end
        SUB: begin
          acc <= x_q - qm;  // wraps modulo 2^(WIDTH+2) on underflow
          cnt <= '0;
        end
        CORR: begin
          if (do_corr) begin
            acc <= acc - m_ext;
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef QCORR_ERR_EN
  logic underflow;
  logic err_q;

  // err is latched when CORR exits so it is stable for the whole DONE phase.
  // Leaving CORR with acc >= m can only mean the correction budget ran out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      err_q     <= 1'b0;
    end else if (state == SUB) begin
      underflow <= (x_q < qm);
      err_q     <= 1'b0;
    end else if ((state == CORR) && !do_corr) begin
      err_q     <= underflow | acc_ge_m;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.r         = acc[WIDTH-1:0];
  assign bus.corr_cnt  = cnt;

endmodule
